// File: rtl/isq_dispatch.sv
// isq_dispatch: write-side driver of the issue queue.
// Takes one renamed micro-op per cycle from rename/dispatch, computes its
// operand sleep bits from a physical-register busy table, and drives the
// queue's write port. It keeps a shadow copy of slot occupancy and sleep
// state so it can turn writebacks into per-slot wake pulses.
module isq_dispatch #(
  parameter int ISSUE_QUEUE_DEPTH = 8,
  parameter int DATA_WIDTH        = 248,
  parameter int PREG_NUM          = 64,
  parameter int IDX_W             = $clog2(ISSUE_QUEUE_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [DATA_WIDTH-1:0] disp_data,
  input  logic                  wb_valid,
  input  logic [5:0]            wb_prd,
  input  logic                  iq_issue_valid,
  input  logic [IDX_W-1:0]      iq_issue_index,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_sleep_rs1,
  output logic                  write_sleep_rs2,
  output logic                  write_enable,
  output logic [IDX_W-1:0]      wake_rs1_index,
  output logic                  wake_rs1_enable,
  output logic [IDX_W-1:0]      wake_rs2_index,
  output logic                  wake_rs2_enable,
  output logic [IDX_W:0]        free_count
);

  localparam int DEPTH = ISSUE_QUEUE_DEPTH;

  // Micro-op field positions inside the packed dispatch word.
  localparam int PRD_LSB     = 124;
  localparam int NEED_WB_BIT = 117;
  localparam int PRS1_LSB    = 111;
  localparam int PRS2_LSB    = 105;
  localparam int SRC1_REG    = 104;
  localparam int SRC2_REG    = 103;

  // Returns {found, index} of the lowest set bit of a slot vector.
  function automatic logic [IDX_W:0] lowest_set(input logic [DEPTH-1:0] vec);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  // Architectural state.
  logic [PREG_NUM-1:0] busy;
  logic [DEPTH-1:0]    slot_valid;
  logic [DEPTH-1:0]    slot_sleep1;
  logic [DEPTH-1:0]    slot_sleep2;
  logic [DEPTH-1:0]    pend1;
  logic [DEPTH-1:0]    pend2;
  logic [5:0]          slot_prs1 [DEPTH];
  logic [5:0]          slot_prs2 [DEPTH];

  // Decoded micro-op fields.
  logic [5:0] uop_prd;
  logic       uop_need_wb;
  logic [5:0] uop_prs1;
  logic [5:0] uop_prs2;
  logic       uop_src1_reg;
  logic       uop_src2_reg;

  assign uop_prd      = disp_data[PRD_LSB +: 6];
  assign uop_need_wb  = disp_data[NEED_WB_BIT];
  assign uop_prs1     = disp_data[PRS1_LSB +: 6];
  assign uop_prs2     = disp_data[PRS2_LSB +: 6];
  assign uop_src1_reg = disp_data[SRC1_REG];
  assign uop_src2_reg = disp_data[SRC2_REG];

  // Allocation and acceptance.
  logic [IDX_W:0]   alloc_sel;
  logic             alloc_found;
  logic [IDX_W-1:0] alloc_idx;
  logic             accept;
  logic             new_sleep1;
  logic             new_sleep2;
  logic             set_busy;

  assign alloc_sel   = lowest_set(~slot_valid);
  assign alloc_found = alloc_sel[IDX_W];
  assign alloc_idx   = alloc_sel[IDX_W-1:0];
  assign disp_ready  = alloc_found;
  assign accept      = disp_valid & disp_ready;
  assign set_busy    = accept & uop_need_wb & (uop_prd != 6'd0);

  // A writeback landing in the acceptance cycle bypasses the busy table.
  assign new_sleep1 = uop_src1_reg & busy[uop_prs1] & ~(wb_valid && (wb_prd == uop_prs1));
  assign new_sleep2 = uop_src2_reg & busy[uop_prs2] & ~(wb_valid && (wb_prd == uop_prs2));

  // Wake arbitration over the registered pending sets.
  logic [DEPTH-1:0] issue_mask;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] wb_match1;
  logic [DEPTH-1:0] wb_match2;
  logic [DEPTH-1:0] grant1_mask;
  logic [DEPTH-1:0] grant2_mask;
  logic [IDX_W:0]   grant1_sel;
  logic [IDX_W:0]   grant2_sel;

  // A slot being issued this cycle no longer needs a wake, so it is not a candidate.
  assign grant1_sel = lowest_set(pend1 & ~issue_mask);
  assign grant2_sel = lowest_set(pend2 & ~issue_mask);

  // Per-slot one-hot masks for issue, allocation, grants and writeback matches.
  always_comb begin
    issue_mask  = '0;
    alloc_mask  = '0;
    grant1_mask = '0;
    grant2_mask = '0;
    wb_match1   = '0;
    wb_match2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issue_mask[i]  = iq_issue_valid && (iq_issue_index == IDX_W'(i));
      alloc_mask[i]  = accept && (alloc_idx == IDX_W'(i));
      grant1_mask[i] = grant1_sel[IDX_W] && (grant1_sel[IDX_W-1:0] == IDX_W'(i));
      grant2_mask[i] = grant2_sel[IDX_W] && (grant2_sel[IDX_W-1:0] == IDX_W'(i));
      wb_match1[i]   = wb_valid && slot_valid[i] && slot_sleep1[i] && (slot_prs1[i] == wb_prd);
      wb_match2[i]   = wb_valid && slot_valid[i] && slot_sleep2[i] && (slot_prs2[i] == wb_prd);
    end
  end

  // Count of free shadow slots, derived from registered occupancy.
  always_comb begin
    free_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_valid[i]) free_count = free_count + (IDX_W + 1)'(1);
    end
  end

  // Busy table: writeback clears, a producing dispatch sets, and set wins a tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      if (wb_valid) busy[wb_prd] <= 1'b0;
      if (set_busy) busy[uop_prd] <= 1'b1;
    end
  end

  // Shadow slot occupancy, source tags and sleep state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid  <= '0;
      slot_sleep1 <= '0;
      slot_sleep2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_prs1[i] <= '0;
        slot_prs2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_mask[i]) begin
          slot_valid[i]  <= 1'b1;
          slot_sleep1[i] <= new_sleep1;
          slot_sleep2[i] <= new_sleep2;
          slot_prs1[i]   <= uop_prs1;
          slot_prs2[i]   <= uop_prs2;
        end else if (issue_mask[i]) begin
          slot_valid[i]  <= 1'b0;
          slot_sleep1[i] <= 1'b0;
          slot_sleep2[i] <= 1'b0;
        end else begin
          if (wb_match1[i]) slot_sleep1[i] <= 1'b0;
          if (wb_match2[i]) slot_sleep2[i] <= 1'b0;
        end
      end
    end
  end

  // Pending wakes: set on a matching writeback, cleared by grant, issue or reallocation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend1 <= '0;
      pend2 <= '0;
    end else begin
      pend1 <= ((pend1 & ~grant1_mask) | wb_match1) & ~issue_mask & ~alloc_mask;
      pend2 <= ((pend2 & ~grant2_mask) | wb_match2) & ~issue_mask & ~alloc_mask;
    end
  end

  // Registered write port toward the issue queue; one pulse per accepted micro-op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_data      <= '0;
      write_sleep_rs1 <= 1'b0;
      write_sleep_rs2 <= 1'b0;
      write_enable    <= 1'b0;
    end else begin
      write_enable    <= accept;
      write_sleep_rs1 <= accept & new_sleep1;
      write_sleep_rs2 <= accept & new_sleep2;
      if (accept) write_data <= disp_data;
    end
  end

  // Registered single-cycle wake pulses, one per source per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wake_rs1_enable <= 1'b0;
      wake_rs1_index  <= '0;
      wake_rs2_enable <= 1'b0;
      wake_rs2_index  <= '0;
    end else begin
      wake_rs1_enable <= grant1_sel[IDX_W];
      wake_rs1_index  <= grant1_sel[IDX_W] ? grant1_sel[IDX_W-1:0] : '0;
      wake_rs2_enable <= grant2_sel[IDX_W];
      wake_rs2_index  <= grant2_sel[IDX_W] ? grant2_sel[IDX_W-1:0] : '0;
    end
  end

endmodule

// File: doc/isq_dispatch.md
Name: isq_dispatch

Overview:
- Write-side driver of the issue queue. It sits between rename/dispatch and the issue queue.
- Accepts one renamed 248-bit micro-op per cycle and drives the queue's write port (write_data, write_sleep_rs1/rs2, write_enable).
- Keeps a physical-register busy table and a shadow copy of queue slot occupancy and sleep state.
- When a writeback releases a sleeping operand, it generates the queue's per-slot wake_rs1/wake_rs2 pulses.

Parameters:
- ISSUE_QUEUE_DEPTH, 8, slot count; must match the issue queue.
- DATA_WIDTH, 248, micro-op entry width.
- PREG_NUM, 64, number of physical registers.
- IDX_W, $clog2(ISSUE_QUEUE_DEPTH), slot index width.

Ports:
- clock  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid  in  1  micro-op offered.
- disp_ready  out  1  micro-op accepted when disp_valid & disp_ready.
- disp_data  in  DATA_WIDTH  packed micro-op. Field positions: prd[129:124], need_to_wb[117], prs1[116:111], prs2[110:105], src1_is_reg[104], src2_is_reg[103].
- wb_valid  in  1  writeback of a physical register this cycle.
- wb_prd  in  6  written physical register.
- iq_issue_valid  in  1  issue queue read a slot this cycle.
- iq_issue_index  in  IDX_W  slot the issue queue read.
- write_data  out  DATA_WIDTH  to issue queue.
- write_sleep_rs1  out  1  to issue queue.
- write_sleep_rs2  out  1  to issue queue.
- write_enable  out  1  to issue queue.
- wake_rs1_index  out  IDX_W  to issue queue.
- wake_rs1_enable  out  1  to issue queue.
- wake_rs2_index  out  IDX_W  to issue queue.
- wake_rs2_enable  out  1  to issue queue.
- free_count  out  IDX_W+1  number of free shadow slots.

Behaviour:
- Reset (asynchronous): busy table all 0; shadow valid/sleep/pending all 0; every output register 0.
  - free_count = ISSUE_QUEUE_DEPTH.
  - disp_ready = 1 once reset is released.
- disp_ready is combinational: 1 when any shadow slot is free. It does not depend on the queue's queue_full, which is registered and arrives too late.
- Slot allocation: lowest-index free shadow slot. This is the same rule the issue queue uses, so the shadow index equals the real slot.
- Sleep bit per source, computed at acceptance: src_is_reg & busy[prs] & !(wb_valid & wb_prd==prs). Writeback in the same cycle bypasses the busy table.
- Acceptance edge E:
  - Registers write_data/sleeps/write_enable=1; these are valid during cycle E..E+1, so the queue writes at edge E+1.
  - Marks the shadow slot valid, stores its prs1/prs2 and sleep bits.
  - If need_to_wb & prd!=0: sets busy[prd].
  - write_enable is 0 in any cycle with no acceptance (single-cycle pulse per micro-op).
- Busy table:
  - wb_valid clears busy[wb_prd].
  - A simultaneous set and clear of the same preg: set wins.
  - preg 0 is never set busy.
- Pending wake: each cycle, for every valid shadow slot with sleep_rsN=1 and prsN==wb_prd under wb_valid, set pending_rsN and clear the shadow sleep_rsN. A matching wb in the acceptance cycle is covered by the bypass, so no pending bit is set.
- Wake arbitration: independent arbiters for rs1 and rs2. Each cycle, pick the lowest-index pending slot, register wake_rsN_enable=1 with its index, and clear that pending bit.
  - One wake per source per cycle.
  - Remaining pendings drain on subsequent cycles.
  - Wake outputs are 1-cycle registered pulses. The earliest wake for a slot is edge E+2, strictly after the queue has written the slot.
- Issue: iq_issue_valid frees shadow slot iq_issue_index and clears its pending bits. A slot freed at edge N is allocatable from cycle N onward.
  - Same-cycle issue and acceptance: acceptance uses the pre-edge free set; it never targets the slot being freed that cycle.
- free_count = popcount of free shadow slots, combinational from registered state.
- Full: free_count==0 gives disp_ready=0 and no write. A micro-op held on disp_valid is accepted in the cycle after an issue frees a slot.
- Reset mid-operation clears everything immediately, including in-flight pendings. The issue queue is reset by the same signal.

Test Plan:
- Reset, then dispatch prs1=5 (not busy), src1_is_reg=1, src2_is_reg=0 -> write_enable pulse one cycle later, sleeps 0/0, slot 0, free_count 7.
- Dispatch A with prd=9, need_to_wb=1, then B with prs1=9 -> B written to slot 1 with write_sleep_rs1=1. Then wb_prd=9 -> wake_rs1_enable=1 with index 1 two cycles after wb, for exactly one cycle.
- B with prs1=9 accepted in the same cycle as wb_prd=9 -> write_sleep_rs1=0, no wake pulse.
- Slots 2, 4, 6 all sleeping on rs2=12; wb_prd=12 -> wake_rs2 indices 2, 4, 6 on three consecutive cycles.
- Fill 8 slots -> disp_ready=0, free_count 0. iq_issue_valid index 3 -> next accepted micro-op lands in slot 3.
- Simultaneous dispatch of prd=20 and wb_prd=20 -> busy[20]=1 afterwards; a later consumer of p20 sleeps. Assert reset_n mid-drain -> all wake/write outputs 0 immediately.
